// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master receive path.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_BYTE_CNT_W = 3;

  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DONE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_rx_hold_buf.sv
// One-entry valid/ready holding register for received words, with sticky overrun flag.
module spi_rx_hold_buf
  import spi_pkg::*;
#(
  parameter int W = SPI_DATA_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         clr_overrun,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         vd,
  output logic         overrun
);

  // Handshake: a word transfers on any cycle with vd=1 and ready=1; vd and
  // data are held unchanged until then. A load in the same cycle as a
  // transfer replaces the word; a load while the slot is full and not being
  // drained is dropped and flags overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data    <= '0;
      vd      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        if (!vd || ready) begin
          data <= load_data;
          vd   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (vd && ready) begin
        vd <= 1'b0;
      end
      if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_rx_shift_reg.sv
// SPI master receive shifter: samples MISO on sample-edge strobes, assembles
// words, counts a multi-word frame and hands words to a holding register.
module spi_rx_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int BYTE_CNT_W = SPI_BYTE_CNT_W,
  parameter bit MSB_FIRST  = BIT_ORDER_MSB_FIRST
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_start,
  input  logic [BYTE_CNT_W-1:0] i_num_bytes,
  input  logic                  i_sample_edge,
  input  logic                  i_miso,
  input  logic                  i_rx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_parallel,
  output logic                  o_rx_vd,
  output logic                  o_rx_busy,
  output logic                  o_rx_done,
  output logic                  o_overrun,
  output logic [2:0]            o_bit_count,
  output logic [BYTE_CNT_W-1:0] o_byte_count
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_next;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q;
  logic [BYTE_CNT_W-1:0]   len_q;
  logic                    start_take;
  logic                    shift_en;
  logic                    word_done;
  logic                    last_word;

  assign start_take = (state_q == RX_IDLE) && i_rx_start;
  assign shift_en   = (state_q == RX_SHIFT) && i_sample_edge;
  assign word_done  = shift_en && (bit_cnt_q == LAST_BIT);
  assign last_word  = (byte_cnt_q == len_q);

  // sr_next already contains the bit being sampled, so it is the completed word.
  always_comb begin
    if (MSB_FIRST == BIT_ORDER_LSB_FIRST) begin
      sr_next = {i_miso, sr_q[DATA_WIDTH-1:1]};
    end else begin
      sr_next = {sr_q[DATA_WIDTH-2:0], i_miso};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_rx_busy = 1'b0;
    o_rx_done = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (i_rx_start) begin
          state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        o_rx_busy = 1'b1;
        if (word_done && last_word) begin
          state_d = RX_DONE;
        end
      end
      RX_DONE: begin
        o_rx_done = 1'b1;
        state_d   = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Counters hold their final values after DONE until the next start clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
    end else if (start_take) begin
      len_q      <= i_num_bytes;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (shift_en) begin
      sr_q <= sr_next;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_q <= '0;
        if (!last_word) begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end else begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  assign o_bit_count  = 3'(bit_cnt_q);
  assign o_byte_count = byte_cnt_q;

  spi_rx_hold_buf #(
    .W (DATA_WIDTH)
  ) u_hold (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .load        (word_done),
    .load_data   (sr_next),
    .clr_overrun (start_take),
    .ready       (i_rx_ready),
    .data        (o_rx_parallel),
    .vd          (o_rx_vd),
    .overrun     (o_overrun)
  );

endmodule

// File: tb/tb_spi_rx_shift_reg.sv
// Bench for spi_rx_shift_reg: MSB-first and LSB-first instances driven in parallel
// against a bit-list reference model, frame table, corner sequences and random frames.
module tb_spi_rx_shift_reg;

  logic       clk;
  logic       drv_rst;
  logic       drv_start;
  logic [2:0] drv_nb;
  logic       drv_edge;
  logic       drv_miso;
  logic       drv_ready;

  logic [7:0] m_parallel, l_parallel;
  logic       m_vd, l_vd, m_busy, l_busy, m_done_o, l_done_o, m_ovr_o, l_ovr_o;
  logic [2:0] m_bitc, l_bitc, m_bytec, l_bytec;

  spi_rx_shift_reg #(.DATA_WIDTH(8), .BYTE_CNT_W(3), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk(clk), .i_rst(drv_rst), .i_rx_start(drv_start), .i_num_bytes(drv_nb),
    .i_sample_edge(drv_edge), .i_miso(drv_miso), .i_rx_ready(drv_ready),
    .o_rx_parallel(m_parallel), .o_rx_vd(m_vd), .o_rx_busy(m_busy), .o_rx_done(m_done_o),
    .o_overrun(m_ovr_o), .o_bit_count(m_bitc), .o_byte_count(m_bytec)
  );

  spi_rx_shift_reg #(.DATA_WIDTH(8), .BYTE_CNT_W(3), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_rst(drv_rst), .i_rx_start(drv_start), .i_num_bytes(drv_nb),
    .i_sample_edge(drv_edge), .i_miso(drv_miso), .i_rx_ready(drv_ready),
    .o_rx_parallel(l_parallel), .o_rx_vd(l_vd), .o_rx_busy(l_busy), .o_rx_done(l_done_o),
    .o_overrun(l_ovr_o), .o_bit_count(l_bitc), .o_byte_count(l_bytec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int done_cnt;
  bit rand_ready;
  bit rand_stray;

  // reference model state: frame progress as a list of received bits
  bit         md_active, md_done, md_vd, md_ovr;
  logic [7:0] md_dmsb, md_dlsb;
  int         md_idx, md_len;
  bit         md_bits[$];

  logic [7:0] exp_q[$];
  logic [7:0] got_msb[$];
  logic [7:0] got_lsb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    bit         new_w;
    bit         nd;
    logic [7:0] wm, wl;
    new_w = 1'b0;
    nd    = 1'b0;
    wm    = '0;
    wl    = '0;
    if (drv_rst) begin
      md_active = 0; md_done = 0; md_vd = 0; md_ovr = 0;
      md_dmsb = '0; md_dlsb = '0; md_idx = 0; md_len = 0;
      md_bits.delete();
    end else begin
      if (!md_active && !md_done) begin
        if (drv_start) begin
          md_active = 1; md_len = int'(drv_nb); md_idx = 0; md_ovr = 0;
          md_bits.delete();
        end
      end else if (md_active && drv_edge) begin
        md_bits.push_back(drv_miso);
        if (md_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            wm = wm + (8'(md_bits[i]) << (7 - i));
            wl = wl + (8'(md_bits[i]) << i);
          end
          new_w = 1'b1;
          md_bits.delete();
          if (md_idx == md_len) begin
            md_active = 0;
            nd = 1'b1;
          end else begin
            md_idx++;
          end
        end
      end
      if (new_w) begin
        if (!md_vd || drv_ready) begin
          md_dmsb = wm; md_dlsb = wl; md_vd = 1;
        end else begin
          md_ovr = 1;
        end
      end else if (md_vd && drv_ready) begin
        md_vd = 0;
      end
      md_done = nd;
    end
  endtask

  task automatic compare_all();
    chk("vd", m_vd, md_vd);
    chk("parallel", m_parallel, md_dmsb);
    chk("overrun", m_ovr_o, md_ovr);
    chk("busy", m_busy, md_active);
    chk("done", m_done_o, md_done);
    chk("bit_count", m_bitc, md_bits.size());
    chk("byte_count", m_bytec, md_idx);
    chk("lsb_vd", l_vd, md_vd);
    chk("lsb_parallel", l_parallel, md_dlsb);
  endtask

  // one clock: scoreboard on handshakes, advance model, sample after the edge
  task automatic cyc();
    if (rand_ready) drv_ready = 1'($urandom_range(0, 1));
    if (!drv_rst) begin
      if (md_vd && drv_ready) exp_q.push_back(md_dmsb);
      if (m_vd && drv_ready) begin
        got_msb.push_back(m_parallel);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", m_parallel, 32'hFFFF_FFFF);
        end else begin
          chk("sb_word", m_parallel, exp_q.pop_front());
        end
      end
      if (l_vd && drv_ready) got_lsb.push_back(l_parallel);
    end
    model_step();
    @(posedge clk);
    #1;
    if (m_done_o) done_cnt++;
    compare_all();
  endtask

  task automatic idle(int n);
    drv_edge = 0;
    drv_start = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drive_bit(bit b, int gap);
    for (int i = 0; i < gap; i++) begin
      drv_edge = 0;
      drv_start = rand_stray && ($urandom_range(0, 15) == 0);
      cyc();
    end
    drv_start = 0;
    drv_edge = 1;
    drv_miso = b;
    cyc();
    drv_edge = 0;
  endtask

  task automatic send_bits(logic [7:0] w, int first, int n);
    for (int i = first; i < first + n; i++) drive_bit(w[7 - i], $urandom_range(0, 2));
  endtask

  task automatic start_frame(logic [2:0] nb);
    drv_start = 1;
    drv_nb = nb;
    cyc();
    drv_start = 0;
  endtask

  typedef struct packed {
    logic [2:0]      nb;
    logic [3:0][7:0] w;
    logic [3:0][7:0] exp_msb;
    logic [3:0][7:0] exp_lsb;
  } vec_t;

  vec_t tbl[4];

  initial begin
    n_vec = 0; n_err = 0; done_cnt = 0;
    rand_ready = 0; rand_stray = 0;
    drv_rst = 1; drv_start = 0; drv_nb = '0; drv_edge = 0; drv_miso = 0; drv_ready = 1;

    tbl[0] = '{nb: 3'd0, w: 32'h0000_00A5, exp_msb: 32'h0000_00A5, exp_lsb: 32'h0000_00A5};
    tbl[1] = '{nb: 3'd0, w: 32'h0000_0080, exp_msb: 32'h0000_0080, exp_lsb: 32'h0000_0001};
    tbl[2] = '{nb: 3'd2, w: 32'h0056_3412, exp_msb: 32'h0056_3412, exp_lsb: 32'h006A_2C48};
    tbl[3] = '{nb: 3'd3, w: 32'hFE01_0FF0, exp_msb: 32'hFE01_0FF0, exp_lsb: 32'h7F80_F00F};

    cyc();
    cyc();
    chk("rst_parallel", m_parallel, 0);
    chk("rst_vd", m_vd, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done_o, 0);
    chk("rst_overrun", m_ovr_o, 0);
    chk("rst_counts", {m_bitc, m_bytec}, 0);
    drv_rst = 0;
    idle(2);

    // frame table, consumer always ready
    for (int t = 0; t < 4; t++) begin
      got_msb.delete();
      got_lsb.delete();
      done_cnt = 0;
      start_frame(tbl[t].nb);
      for (int k = 0; k <= int'(tbl[t].nb); k++) send_bits(tbl[t].w[k], 0, 8);
      idle(3);
      chk("tbl_word_count", got_msb.size(), int'(tbl[t].nb) + 1);
      chk("tbl_lsb_word_count", got_lsb.size(), int'(tbl[t].nb) + 1);
      for (int k = 0; k <= int'(tbl[t].nb); k++) begin
        if (k < got_msb.size()) chk("tbl_msb_word", got_msb[k], tbl[t].exp_msb[k]);
        if (k < got_lsb.size()) chk("tbl_lsb_word", got_lsb[k], tbl[t].exp_lsb[k]);
      end
      chk("tbl_done_pulses", done_cnt, 1);
      chk("tbl_overrun", m_ovr_o, 0);
    end

    // overrun: consumer stalled across two words
    drv_ready = 0;
    start_frame(3'd1);
    send_bits(8'h11, 0, 8);
    send_bits(8'h22, 0, 8);
    chk("ovr_held_word", m_parallel, 8'h11);
    chk("ovr_vd", m_vd, 1);
    chk("ovr_flag", m_ovr_o, 1);
    chk("ovr_done", m_done_o, 1);
    drv_ready = 1;
    cyc();
    chk("ovr_vd_cleared", m_vd, 0);
    chk("ovr_sticky", m_ovr_o, 1);
    idle(2);
    chk("ovr_sticky_idle", m_ovr_o, 1);

    // accept and complete in the same cycle
    drv_ready = 0;
    start_frame(3'd1);
    chk("start_clears_overrun", m_ovr_o, 0);
    send_bits(8'h11, 0, 8);
    send_bits(8'h22, 0, 7);
    drv_ready = 1;
    drive_bit(1'b0, 0);
    chk("simul_word", m_parallel, 8'h22);
    chk("simul_vd", m_vd, 1);
    chk("simul_overrun", m_ovr_o, 0);
    idle(2);

    // reset mid-frame, stray edges in IDLE, start while busy
    start_frame(3'd0);
    send_bits(8'hFF, 0, 4);
    drv_rst = 1;
    cyc();
    chk("midrst_outputs", {m_parallel, m_vd, m_busy, m_done_o, m_ovr_o, m_bitc, m_bytec}, 0);
    drv_rst = 0;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 0);
    chk("idle_edges_bitc", m_bitc, 0);
    chk("idle_edges_busy", m_busy, 0);
    drv_start = 1; drv_nb = 3'd0; drv_edge = 1; drv_miso = 1;
    cyc();
    drv_start = 0; drv_edge = 0;
    chk("start_edge_bitc", m_bitc, 0);
    chk("start_edge_busy", m_busy, 1);
    send_bits(8'hC3, 0, 3);
    drv_start = 1; drv_nb = 3'd5;
    cyc();
    drv_start = 0;
    chk("busy_start_ignored", {m_busy, m_bitc, m_bytec}, {1'b1, 3'd3, 3'd0});
    send_bits(8'hC3, 3, 5);
    chk("c3_msb", m_parallel, 8'hC3);
    chk("c3_lsb", l_parallel, 8'hC3);
    chk("c3_done", m_done_o, 1);
    idle(2);

    // random frames, random back-pressure, stray starts while shifting
    rand_ready = 1;
    rand_stray = 1;
    for (int f = 0; f < 40; f++) begin
      start_frame(3'($urandom_range(0, 7)));
      for (int k = 0; k <= md_len; k++) send_bits(8'($urandom), 0, 8);
      idle($urandom_range(0, 3));
    end
    rand_ready = 0;
    rand_stray = 0;
    drv_ready = 1;
    idle(3);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_rx_shift_reg.md
Name: spi_rx_shift_reg

Overview:
Serial-in/parallel-out receive shift register for the SPI master. It is the receive-side counterpart of the MOSI transmit shifter.
- Samples i_miso on sample-edge strobes from the SPI clock generator.
- Assembles bytes and counts a multi-byte frame.
- Hands each completed byte to the consumer through a one-entry valid/ready holding register, with overrun detection.
- Runs entirely on the system clock, never on spi_clk.

Parameters:
DATA_WIDTH, 8, bits per received word
BYTE_CNT_W, 3, width of byte counter; frame length 1..2**BYTE_CNT_W words
MSB_FIRST, 1, 1 = first sampled bit lands in MSB; 0 = first sampled bit lands in LSB

Ports:
i_clk  in  1  system clock; the block's only clock
i_rst  in  1  reset, synchronous, active-high
i_rx_start  in  1  one-cycle pulse that starts a frame; latches i_num_bytes
i_num_bytes  in  BYTE_CNT_W  frame length minus 1 (0 = 1 byte, 7 = 8 bytes)
i_sample_edge  in  1  one-cycle strobe at the SPI sampling edge
i_miso  in  1  serial data from slave, pre-synchronised
i_rx_ready  in  1  consumer accepts o_rx_parallel when o_rx_vd=1
o_rx_parallel  out  DATA_WIDTH  received word (holding register)
o_rx_vd  out  1  holding register valid
o_rx_busy  out  1  frame in progress
o_rx_done  out  1  one-cycle pulse when the frame's last word is captured
o_overrun  out  1  sticky; a completed word was dropped
o_bit_count  out  3  current bit index within the word
o_byte_count  out  BYTE_CNT_W  current word index within the frame

Behaviour:
- Reset: synchronous on posedge i_clk while i_rst=1. All of the following are 0 after reset:
  - outputs: o_rx_parallel, o_rx_vd, o_rx_busy, o_rx_done, o_overrun, o_bit_count, o_byte_count
  - internal shift register and latched length
  - state = IDLE
- Reset mid-frame: abandons the frame immediately; the partial word is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: i_rx_start=1 → latch i_num_bytes, clear both counters, clear o_overrun, go to SHIFT. i_sample_edge is ignored in IDLE.
  - SHIFT: on each cycle with i_sample_edge=1:
    - MSB_FIRST=1: sr <= {sr[W-2:0], i_miso}. MSB_FIRST=0: sr <= {i_miso, sr[W-1:1]}.
    - bit_cnt increments.
    - When bit_cnt == W-1 on that edge, the word is complete: the assembled word (including the current i_miso) goes to the holding register, bit_cnt wraps to 0 and byte_cnt increments.
    - If the completed word's byte_cnt equals the latched length, go to DONE instead of incrementing.
  - DONE: o_rx_done=1 for exactly this one cycle, then IDLE. o_rx_busy=0 in DONE.
- o_rx_busy = 1 exactly while in SHIFT.
- Latency: o_rx_vd and o_rx_parallel are valid on the cycle after the clock edge that sampled the last bit. o_rx_done rises in that same cycle (the first DONE cycle).
- Holding-register handshake:
  - o_rx_vd stays high and o_rx_parallel stays stable until a cycle with o_rx_vd=1 and i_rx_ready=1; o_rx_vd clears at the next edge.
  - Word completes while o_rx_vd=1 and i_rx_ready=0: the new word is dropped, the held word is kept, and o_overrun is set.
  - Word completes while o_rx_vd=1 and i_rx_ready=1 in the same cycle: the old word is consumed, the new word is loaded, o_rx_vd stays 1, and there is no overrun.
  - o_overrun is cleared only by reset or the next accepted i_rx_start.
- Start/edge collisions:
  - i_rx_start while in SHIFT or DONE is ignored.
  - i_rx_start and i_sample_edge in the same IDLE cycle: start is taken, the edge is ignored.
- Counter wrap: byte_cnt never exceeds the latched length; maximum frame length is 2**BYTE_CNT_W words.
- o_bit_count and o_byte_count are registered copies of the internal counters.

Decomposition:
- Shared package spi_pkg:
  - rx FSM state encoding (IDLE/SHIFT/DONE)
  - DATA_WIDTH and BYTE_CNT_W default constants
  - bit-order constants (MSB_FIRST/LSB_FIRST)
- Sub-module spi_rx_hold_buf: the one-entry valid/ready holding register with overrun detection.
- The FSM, counters and shifter remain in the top module.

Test Plan:
- Single byte, MSB_FIRST=1: i_num_bytes=0, start, 8 edges with miso bits 1,0,1,0,0,1,0,1, i_rx_ready=1 → o_rx_parallel=0xA5 and o_rx_vd=1 for one cycle; o_rx_done pulse in the same cycle; o_rx_busy falls; o_overrun=0.
- LSB_FIRST build, same bit stream → o_rx_parallel=0xA5 bit-reversed = 0xA5 (palindrome). Then stream 1,0,0,0,0,0,0,0 → MSB_FIRST gives 0x80, LSB_FIRST gives 0x01.
- 3-byte frame: i_num_bytes=2, stream 0x12,0x34,0x56, i_rx_ready=1 → three o_rx_vd pulses with values in that order; o_byte_count steps 0,1,2; one o_rx_done after 0x56.
- Overrun: 2-byte frame 0x11,0x22, i_rx_ready=0 throughout → o_rx_parallel stays 0x11; o_overrun=1 after the second word; then i_rx_ready=1 → o_rx_vd clears; o_overrun stays set until the next start.
- Simultaneous accept and complete: hold 0x11 with i_rx_ready held low, then raise i_rx_ready in the exact cycle the 8th bit of 0x22 is sampled → o_rx_parallel=0x22, o_rx_vd stays 1, o_overrun=0.
- Reset mid-frame, plus ignored edges: i_rst=1 after 4 edges → all outputs 0 next cycle. Edges in IDLE and a second start while busy → no effect; next clean frame 0xC3 is received correctly.
